// File: rtl/decode_arbiter.sv
// Round-robin arbiter that lets two receive requesters share one combinational decoder.
// It registers the winner's code onto the decoder and returns the result over a valid/ready port.
module decode_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] code_a,
  input  logic [DATA_W-1:0] code_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] dec_in,
  input  logic [DATA_W-1:0] dec_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

  state_t            state_q, state_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              grant_id_q, grant_id_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_id_q, out_id_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] dec_in_q, dec_in_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              winner;

  always_comb begin
    state_d     = state_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    dec_in_d    = dec_in_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
    // A lone requester wins outright; a tie goes to the round-robin pointer.
    winner      = (req_a && req_b) ? rr_ptr_q : req_b;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          dec_in_d   = winner ? code_b : code_a;
          ack_a_d    = ~winner;
          ack_b_d    = winner;
          grant_id_d = winner;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        out_data_d  = dec_out;
        out_id_d    = grant_id_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = ~grant_id_q;
          word_cnt_d  = word_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      grant_id_q  <= 1'b0;
      rr_ptr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      dec_in_q    <= '0;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      busy_q      <= busy_d;
      dec_in_q    <= dec_in_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign dec_in    = dec_in_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = busy_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_decode_arbiter.sv
// Bench for decode_arbiter: a transaction-level model checked every cycle, plus directed
// scenarios with hand-computed expectations. A narrow-counter and a full-width instance share stimulus.
module tb_decode_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
  logic [7:0] code_a = 8'h00, code_b = 8'h00;

  logic       ack_a, ack_b, out_valid, out_id, busy;
  logic [7:0] dec_in, dec_out, out_data;
  logic [1:0] word_cnt;

  logic        ack_a16, ack_b16, out_valid16, out_id16, busy16;
  logic [7:0]  dec_in16, dec_out16, out_data16;
  logic [15:0] word_cnt16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in decoder: nibble swap then XOR with a fixed mask.
  function automatic logic [7:0] dec_fn(input logic [7:0] x);
    return {x[3:0], x[7:4]} ^ 8'h5A;
  endfunction

  assign dec_out   = dec_fn(dec_in);
  assign dec_out16 = dec_fn(dec_in16);

  decode_arbiter #(.DATA_W(8), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .code_a(code_a), .code_b(code_b), .ack_a(ack_a), .ack_b(ack_b),
    .dec_in(dec_in), .dec_out(dec_out), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .busy(busy), .word_cnt(word_cnt)
  );

  decode_arbiter #(.DATA_W(8), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .code_a(code_a), .code_b(code_b), .ack_a(ack_a16), .ack_b(ack_b16),
    .dec_in(dec_in16), .dec_out(dec_out16), .out_valid(out_valid16),
    .out_data(out_data16), .out_id(out_id16), .out_ready(out_ready),
    .busy(busy16), .word_cnt(word_cnt16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: one word in flight, tracked by its age in cycles since the grant edge.
  logic       m_busy = 0, m_ack_a = 0, m_ack_b = 0, m_valid = 0, m_id = 0, m_rr = 0, m_gid = 0;
  logic [7:0] m_dec_in = 0, m_data = 0;
  int         m_age = 0;
  int         m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ack_a = 0; m_ack_b = 0; m_valid = 0; m_id = 0; m_rr = 0; m_gid = 0;
      m_dec_in = 0; m_data = 0; m_age = 0; m_cnt = 0;
    end else begin
      m_ack_a = 0;
      m_ack_b = 0;
      if (!m_busy) begin
        if (req_a || req_b) begin
          m_gid    = (req_a && req_b) ? m_rr : req_b;
          m_dec_in = m_gid ? code_b : code_a;
          if (m_gid) m_ack_b = 1; else m_ack_a = 1;
          m_busy = 1;
          m_age  = 0;
        end
      end else begin
        m_age++;
        if (m_age == 2) begin
          m_valid = 1;
          m_data  = dec_fn(m_dec_in);
          m_id    = m_gid;
        end else if (m_age >= 3 && out_ready) begin
          m_valid = 0;
          m_rr    = !m_gid;
          m_cnt++;
          m_busy  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack_a", 32'(ack_a), 32'(m_ack_a));
      chk("ack_b", 32'(ack_b), 32'(m_ack_b));
      chk("dec_in", 32'(dec_in), 32'(m_dec_in));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_id", 32'(out_id), 32'(m_id));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt % 4));
      chk("word_cnt16", 32'(word_cnt16), 32'(m_cnt % 65536));
    end
  end

  task automatic wait_for(input int sel, input string name);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = ack_a;
        1:       hit = ack_b;
        2:       hit = out_valid;
        default: hit = !busy;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=not_seen required=seen", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 0; req_b = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gid[$], gt[$], gdat[$];
    int ackb_seen;
    int cnt_seq[5];
    int exp_seq[5];

    do_reset();
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_dec_in", 32'(dec_in), 0);
    chk("reset_word_cnt", 32'(word_cnt), 0);
    $display("txn reset done");

    // Single request.
    code_a = 8'h6C; req_a = 1; out_ready = 1;
    wait_for(0, "single_ack");
    req_a = 0;
    chk("single_dec_in", 32'(dec_in), 32'h6C);
    chk("single_ackb", 32'(ack_b), 0);
    @(negedge clk);
    chk("single_ack_one_cycle", 32'(ack_a), 0);
    chk("single_valid_early", 32'(out_valid), 0);
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'h9C);
    chk("single_id", 32'(out_id), 0);
    @(negedge clk);
    chk("single_cnt", 32'(word_cnt), 1);
    chk("single_valid_drop", 32'(out_valid), 0);
    $display("txn single data=%0h id=%0d cnt=%0d", out_data, out_id, word_cnt);

    // Arbitration with both requesters held.
    do_reset();
    code_a = 8'h6C; code_b = 8'h84; req_a = 1; req_b = 1; out_ready = 1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (ack_a) begin gid.push_back(0); gt.push_back(i); end
      if (ack_b) begin gid.push_back(1); gt.push_back(i); end
      if (out_valid) gdat.push_back(int'(out_data));
    end
    req_a = 0; req_b = 0;
    wait_for(3, "arb_idle");
    chk("arb_grants", 32'(gid.size() >= 4), 1);
    chk("arb_words", 32'(gdat.size() >= 4), 1);
    if (gid.size() >= 4 && gdat.size() >= 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("arb_id", 32'(gid[j]), 32'(j % 2));
        chk("arb_data", 32'(gdat[j]), (j % 2) ? 32'h12 : 32'h9C);
        if (j > 0) chk("arb_spacing", 32'(gt[j] - gt[j-1]), 4);
        $display("txn arb grant=%0d id=%0d data=%0h", j, gid[j], gdat[j]);
      end
    end

    // Backpressure with B pending.
    do_reset();
    code_a = 8'h6C; req_a = 1; out_ready = 0;
    wait_for(0, "bp_ack_a");
    req_a = 0; code_b = 8'h84; req_b = 1;
    wait_for(2, "bp_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(out_valid), 1);
      chk("bp_data_hold", 32'(out_data), 32'h9C);
      chk("bp_id_hold", 32'(out_id), 0);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_no_ack_b", 32'(ack_b), 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_accept", 32'(out_valid), 0);
    chk("bp_idle", 32'(busy), 0);
    chk("bp_cnt", 32'(word_cnt), 1);
    @(negedge clk);
    chk("bp_grant_b", 32'(ack_b), 1);
    chk("bp_dec_in_b", 32'(dec_in), 32'h84);
    req_b = 0;
    wait_for(3, "bp_idle_end");
    $display("txn backpressure cnt=%0d", word_cnt);

    // Late drop of req_b while in HOLD.
    code_a = 8'h11; req_a = 1; out_ready = 0;
    wait_for(0, "late_ack_a");
    req_a = 0;
    wait_for(2, "late_valid");
    @(negedge clk);
    req_b = 1; code_b = 8'h22;
    @(negedge clk);
    req_b = 0;
    repeat (2) @(negedge clk);
    out_ready = 1;
    ackb_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_b) ackb_seen++;
    end
    chk("late_no_ack_b", 32'(ackb_seen), 0);
    chk("late_idle", 32'(busy), 0);
    $display("txn late_drop ack_b_count=%0d", ackb_seen);

    // Reset during CAPTURE with req_a held.
    code_a = 8'h3A; req_a = 1; out_ready = 1;
    wait_for(0, "rst_ack_a");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_dec_in", 32'(dec_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(word_cnt), 0);
    chk("rst_cnt16", 32'(word_cnt16), 0);
    chk("rst_ack", 32'({ack_a, ack_b}), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_for(0, "rst_reack");
    req_a = 0;
    chk("rst_reack_dec_in", 32'(dec_in), 32'h3A);
    wait_for(2, "rst_reword");
    chk("rst_reword_data", 32'(out_data), 32'hF9);
    wait_for(3, "rst_idle");
    $display("txn reset_mid data=F9 expected cnt=%0d", word_cnt);

    // Counter wrap on the 2-bit instance.
    do_reset();
    code_a = 8'h6C; req_a = 1; out_ready = 1;
    exp_seq = '{1, 2, 3, 0, 1};
    for (int t = 0; t < 5; t++) begin
      wait_for(2, "wrap_valid");
      @(negedge clk);
      cnt_seq[t] = int'(word_cnt);
      if (t == 4) req_a = 0;
    end
    for (int t = 0; t < 5; t++) begin
      chk("wrap_cnt", 32'(cnt_seq[t]), 32'(exp_seq[t]));
      $display("txn wrap transfer=%0d word_cnt=%0d", t + 1, cnt_seq[t]);
    end
    wait_for(3, "wrap_idle");
    chk("wrap_cnt16", 32'(word_cnt16), 5);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_arbiter.md
# decode_arbiter

Two-requester round-robin controller that shares the single combinational `decoder` (8-bit code in, 8-bit data out) on the receive side. It registers the selected requester's code onto the decoder input and captures the decoder result one settle cycle later. It then presents the result to a downstream consumer with a valid/ready handshake, tagged with the requester id. It sits between the receive channel front-ends and the downstream data sink.

## Interface
- `DATA_W`, 8, code/data width; fixed to the decoder width
- `CNT_W`, 16, width of completed-word counter
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_a` / `req_b` in 1: requester A/B has a code word pending
- `code_a` / `code_b` in DATA_W: encoded word, stable while req high until ack
- `ack_a` / `ack_b` out 1: one-cycle pulse, word accepted
- `dec_in` out DATA_W: registered drive to decoder `data_in`
- `dec_out` in DATA_W: decoder `data_out`
- `out_valid` out 1: decoded word available
- `out_data` out DATA_W: decoded word
- `out_id` out 1: source of out_data (0=A, 1=B)
- `out_ready` in 1: consumer accepts when high with out_valid
- `busy` out 1: state != IDLE
- `word_cnt` out CNT_W: completed transfers, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, DRIVE, CAPTURE, HOLD.
- **IDLE**
  - No req: stay.
  - Any req: select a winner.
    - Only one requester high: grant it.
    - Both high: grant `rr_ptr`.
  - At the edge: `dec_in<=code_winner`, `ack_winner<=1`, `grant_id<=winner`, go DRIVE.
- **DRIVE**: `ack_*<=0`, go CAPTURE. This is the decoder settle cycle.
- **CAPTURE**: `out_data<=dec_out`, `out_id<=grant_id`, `out_valid<=1`, go HOLD.
- **HOLD**
  - While `out_ready==0`: out_valid, out_data and out_id hold.
  - When `out_valid && out_ready` are sampled: `out_valid<=0`, `rr_ptr<=~grant_id`, `word_cnt<=word_cnt+1`, go IDLE.
- `dec_in` holds its last value outside IDLE transitions, so the decoder input stays stable through CAPTURE.
- **Requester rules**
  - A requester keeps req and code stable until it sees ack.
  - After ack it may keep req high with a new code. That code must be valid by the next IDLE sample, which is no earlier than 3 edges after ack.
  - A requester that drops req before ack is simply not granted. The block does not treat this as an error.
- `req_*` is ignored outside IDLE. Only one word is ever in flight.
- **Reset**: async assertion at any time, including mid-transfer.
  - The in-flight word is discarded and no ack is re-issued.
  - All outputs clear immediately: state=IDLE, ack_a=ack_b=0, dec_in=0, out_valid=0, out_data=0, out_id=0, busy=0, word_cnt=0, rr_ptr=0 (A preferred).

## Timing
- With req sampled at edge k in IDLE:
  - ack high during cycle k..k+1.
  - out_valid high after edge k+2.
  - Earliest out_valid&&out_ready acceptance is at edge k+3, and the next grant is at edge k+4.
- Latency from req sample to out_valid is 2 cycles.
- Throughput is at most 1 word / 4 cycles.
- ack_a and ack_b are never high together.
- ack is never high for more than one cycle per grant.
- busy = (state != IDLE), registered with the state.
- word_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Simultaneous requests alternate A,B,A,B... starting from A after reset.

## Test plan
- **Single request**
  - Stimulus: reset, req_a=1, code_a=0x6C, out_ready=1.
  - Required: ack_a for exactly one cycle, dec_in=0x6C, out_valid 2 cycles after grant with out_data=decoder(0x6C), out_id=0, word_cnt=1.
- **Arbitration**
  - Stimulus: req_a=req_b=1 held, code_a=0x6C, code_b=0x84, out_ready=1.
  - Required: grants A,B,A,B spaced 4 cycles apart; out_id 0,1,0,1; out_data alternating decoder(0x6C)/decoder(0x84).
- **Backpressure**
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Required: out_valid, out_data and out_id stable; busy=1; no ack to a pending req_b; on out_ready=1, one transfer, then B granted.
- **Reset mid-transfer**
  - Stimulus: deassert rst_n asynchronously during CAPTURE.
  - Required: out_valid=0, dec_in=0, busy=0, word_cnt=0 immediately; after release, a held req_a gets a fresh ack and word.
- **Late drop**
  - Stimulus: req_b pulsed for 1 cycle while the block is in HOLD.
  - Required: never granted, ack_b stays 0.
- **Counter wrap**
  - Stimulus: CNT_W=2, 5 transfers.
  - Required: word_cnt sequence 1,2,3,0,1.
